// File: rtl/bsg_cache_dma_sched_pkg.sv
// Shared types and helpers for the cache DMA scheduler.
//   bsg_cache_dma_sched_state_e : packet FSM states (IDLE, ISSUE)
//   safe_clog2                  : clog2 that never returns 0, so every index or
//                                 counter field is at least one bit wide
//   dma_pkt_width               : DMA packet width for a given address width.
//                                 Packet layout is {write_not_read, addr}.
package bsg_cache_dma_sched_pkg;

    typedef enum logic [0:0] {
        IDLE,
        ISSUE
    } bsg_cache_dma_sched_state_e;

    function automatic int unsigned safe_clog2(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int unsigned dma_pkt_width(input int unsigned addr_w);
        return addr_w + 1;
    endfunction

endpackage

// File: rtl/bsg_cache_dma_sched_chan.sv
// One steering channel of the DMA scheduler: an in-order queue of requester
// ids for issued packets, plus a beat counter for the burst at its head.
//   clk_i, reset_i : clock, asynchronous active-low reset
//   push_i         : record push_id_i as the newest issued packet's owner
//   push_id_i      : requester id of that packet
//   beat_i         : one data word of the head burst transferred this cycle
//   full_o         : queue holds els_p ids; no further packet of this type may issue
//   v_o            : queue not empty; id_o is valid
//   id_o           : owner of the oldest outstanding burst
// The head is popped on the last beat of its burst. A push and a pop in the
// same cycle leave occupancy unchanged.
module bsg_cache_dma_sched_chan
    import bsg_cache_dma_sched_pkg::*;
#(
    parameter int unsigned els_p                 = 4,
    parameter int unsigned block_size_in_words_p = 8,
    parameter int unsigned id_width_p            = 2
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  push_i,
    input  logic [id_width_p-1:0] push_id_i,
    input  logic                  beat_i,
    output logic                  full_o,
    output logic                  v_o,
    output logic [id_width_p-1:0] id_o
);

    localparam int unsigned ptr_w_lp = safe_clog2(els_p);
    localparam int unsigned occ_w_lp = $clog2(els_p + 1);
    localparam int unsigned cnt_w_lp = safe_clog2(block_size_in_words_p);

    localparam logic [ptr_w_lp-1:0] last_ptr_lp = ptr_w_lp'(els_p - 1);
    localparam logic [occ_w_lp-1:0] full_occ_lp = occ_w_lp'(els_p);
    localparam logic [cnt_w_lp-1:0] last_cnt_lp = cnt_w_lp'(block_size_in_words_p - 1);

    logic [id_width_p-1:0] mem_q [els_p];
    logic [ptr_w_lp-1:0]   rptr_q, rptr_d;
    logic [ptr_w_lp-1:0]   wptr_q, wptr_d;
    logic [occ_w_lp-1:0]   occ_q, occ_d;
    logic [cnt_w_lp-1:0]   cnt_q, cnt_d;
    logic                  pop;

    assign v_o    = (occ_q != '0);
    assign full_o = (occ_q == full_occ_lp);
    assign id_o   = mem_q[rptr_q];

    // With a one-word burst the counter sits at zero and every beat pops.
    assign pop = beat_i & v_o & (cnt_q == last_cnt_lp);

    always_comb begin
        rptr_d = rptr_q;
        wptr_d = wptr_q;
        occ_d  = occ_q;
        cnt_d  = cnt_q;
        if (push_i) begin
            wptr_d = (wptr_q == last_ptr_lp) ? '0 : wptr_q + 1'b1;
        end
        if (pop) begin
            rptr_d = (rptr_q == last_ptr_lp) ? '0 : rptr_q + 1'b1;
            cnt_d  = '0;
        end else if (beat_i & v_o) begin
            cnt_d = cnt_q + 1'b1;
        end
        case ({push_i, pop})
            2'b10:   occ_d = occ_q + 1'b1;
            2'b01:   occ_d = occ_q - 1'b1;
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            rptr_q <= '0;
            wptr_q <= '0;
            occ_q  <= '0;
            cnt_q  <= '0;
        end else begin
            rptr_q <= rptr_d;
            wptr_q <= wptr_d;
            occ_q  <= occ_d;
            cnt_q  <= cnt_d;
        end
    end

    // Id storage needs no reset: entries are only read while occupancy covers them.
    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_q[wptr_q] <= push_id_i;
        end
    end

endmodule

// File: rtl/bsg_cache_dma_sched.sv
// Shares one memory-side DMA link among num_req_p cache DMA requesters.
// Packets are arbitrated round-robin and issued one at a time; read-fill and
// write-evict bursts are steered to/from their owners strictly in issue
// order per type, with the read and write paths running concurrently.
//   clk_i, reset_i       : clock, asynchronous active-low reset
//   up_pkt_i/_v_i        : per-requester DMA packet {write_not_read, addr}
//   up_pkt_ready_o       : packet accepted this cycle (one-hot)
//   up_data_o/_v_o       : fill data (broadcast) / valid one-hot to owner
//   up_data_yumi_i       : owner consumed the fill word
//   up_data_i/_v_i       : per-requester evict data / valid
//   up_data_ready_o      : evict word taken from that requester
//   down_pkt_o/_v_o      : packet to the DMA engine, held until down_pkt_yumi_i
//   down_data_i/_v_i     : fill data from DMA; down_data_ready_o when routed
//   down_data_o/_v_o     : evict data to DMA; down_data_yumi_i when taken
module bsg_cache_dma_sched
    import bsg_cache_dma_sched_pkg::*;
#(
    parameter int unsigned num_req_p             = 4,
    parameter int unsigned addr_width_p          = 32,
    parameter int unsigned data_width_p          = 64,
    parameter int unsigned block_size_in_words_p = 8,
    parameter int unsigned rd_outstanding_p      = 4,
    parameter int unsigned wr_outstanding_p      = 2,
    localparam int unsigned lg_num_req_lp        = safe_clog2(num_req_p),
    localparam int unsigned dma_pkt_width_lp     = dma_pkt_width(addr_width_p)
) (
    input  logic                                        clk_i,
    input  logic                                        reset_i,

    input  logic [num_req_p-1:0][dma_pkt_width_lp-1:0]  up_pkt_i,
    input  logic [num_req_p-1:0]                        up_pkt_v_i,
    output logic [num_req_p-1:0]                        up_pkt_ready_o,

    output logic [data_width_p-1:0]                     up_data_o,
    output logic [num_req_p-1:0]                        up_data_v_o,
    input  logic [num_req_p-1:0]                        up_data_yumi_i,

    input  logic [num_req_p-1:0][data_width_p-1:0]      up_data_i,
    input  logic [num_req_p-1:0]                        up_data_v_i,
    output logic [num_req_p-1:0]                        up_data_ready_o,

    output logic [dma_pkt_width_lp-1:0]                 down_pkt_o,
    output logic                                        down_pkt_v_o,
    input  logic                                        down_pkt_yumi_i,

    input  logic [data_width_p-1:0]                     down_data_i,
    input  logic                                        down_data_v_i,
    output logic                                        down_data_ready_o,

    output logic [data_width_p-1:0]                     down_data_o,
    output logic                                        down_data_v_o,
    input  logic                                        down_data_yumi_i
);

    bsg_cache_dma_sched_state_e state_q, state_d;

    logic [dma_pkt_width_lp-1:0] pkt_q, pkt_d;
    logic [lg_num_req_lp-1:0]    id_q, id_d;
    logic [lg_num_req_lp-1:0]    ptr_q, ptr_d;

    logic [num_req_p-1:0]        eligible;
    logic                        grant_found;
    logic [lg_num_req_lp-1:0]    grant_id;

    logic                        rd_push, rd_full, rd_v, rd_beat;
    logic                        wr_push, wr_full, wr_v, wr_beat;
    logic [lg_num_req_lp-1:0]    rd_id, wr_id;

    // A packet may only compete if its type's id queue has room.
    always_comb begin
        eligible = '0;
        for (int unsigned i = 0; i < num_req_p; i++) begin
            eligible[i] = up_pkt_v_i[i] &
                (up_pkt_i[i][addr_width_p] ? ~wr_full : ~rd_full);
        end
    end

    // Round robin: first eligible requester at or after the pointer.
    always_comb begin
        int unsigned idx;
        idx         = 0;
        grant_found = 1'b0;
        grant_id    = '0;
        for (int unsigned k = 0; k < num_req_p; k++) begin
            idx = (32'(ptr_q) + k) % num_req_p;
            if (!grant_found && eligible[idx]) begin
                grant_found = 1'b1;
                grant_id    = lg_num_req_lp'(idx);
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        pkt_d          = pkt_q;
        id_d           = id_q;
        ptr_d          = ptr_q;
        up_pkt_ready_o = '0;
        down_pkt_v_o   = 1'b0;
        rd_push        = 1'b0;
        wr_push        = 1'b0;
        case (state_q)
            IDLE: begin
                // Reset is combinationally folded in so no ready leaks while held.
                if (grant_found && reset_i) begin
                    up_pkt_ready_o[grant_id] = 1'b1;
                    pkt_d   = up_pkt_i[grant_id];
                    id_d    = grant_id;
                    ptr_d   = (grant_id == lg_num_req_lp'(num_req_p - 1)) ? '0 : grant_id + 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                down_pkt_v_o = 1'b1;
                if (down_pkt_yumi_i) begin
                    rd_push = ~pkt_q[addr_width_p];
                    wr_push =  pkt_q[addr_width_p];
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q <= IDLE;
            pkt_q   <= '0;
            id_q    <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            pkt_q   <= pkt_d;
            id_q    <= id_d;
            ptr_q   <= ptr_d;
        end
    end

    assign down_pkt_o = pkt_q;

    bsg_cache_dma_sched_chan #(
        .els_p                 (rd_outstanding_p),
        .block_size_in_words_p (block_size_in_words_p),
        .id_width_p            (lg_num_req_lp)
    ) rd_chan (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .push_i    (rd_push),
        .push_id_i (id_q),
        .beat_i    (rd_beat),
        .full_o    (rd_full),
        .v_o       (rd_v),
        .id_o      (rd_id)
    );

    bsg_cache_dma_sched_chan #(
        .els_p                 (wr_outstanding_p),
        .block_size_in_words_p (block_size_in_words_p),
        .id_width_p            (lg_num_req_lp)
    ) wr_chan (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .push_i    (wr_push),
        .push_id_i (id_q),
        .beat_i    (wr_beat),
        .full_o    (wr_full),
        .v_o       (wr_v),
        .id_o      (wr_id)
    );

    // Read steering: fill words go to the owner of the oldest outstanding read.
    assign up_data_o         = down_data_i;
    assign down_data_ready_o = rd_v & up_data_yumi_i[rd_id];
    assign rd_beat           = down_data_v_i & down_data_ready_o;

    // Write steering: evict words are drawn from the oldest outstanding writer.
    assign down_data_o   = up_data_i[wr_id];
    assign down_data_v_o = wr_v & up_data_v_i[wr_id];
    assign wr_beat       = down_data_v_o & down_data_yumi_i;

    always_comb begin
        up_data_v_o     = '0;
        up_data_ready_o = '0;
        if (rd_v) begin
            up_data_v_o[rd_id] = down_data_v_i;
        end
        if (wr_v) begin
            up_data_ready_o[wr_id] = wr_beat;
        end
    end

    // Fill data with no outstanding read has nowhere to go.
    fill_has_owner: assert property (@(posedge clk_i) disable iff (!reset_i)
        down_data_v_i |-> rd_v);

endmodule

// File: tb/tb_bsg_cache_dma_sched.sv
module tb_bsg_cache_dma_sched;

    localparam int unsigned N   = 4;
    localparam int unsigned AW  = 32;
    localparam int unsigned DW  = 64;
    localparam int unsigned BLK = 8;
    localparam int unsigned RDO = 4;
    localparam int unsigned WRO = 2;
    localparam int unsigned PW  = AW + 1;

    logic                    clk = 1'b0;
    logic                    reset_i;
    logic [N-1:0][PW-1:0]    up_pkt_i;
    logic [N-1:0]            up_pkt_v_i;
    logic [N-1:0]            up_pkt_ready_o;
    logic [DW-1:0]           up_data_o;
    logic [N-1:0]            up_data_v_o;
    logic [N-1:0]            up_data_yumi_i;
    logic [N-1:0][DW-1:0]    up_data_i;
    logic [N-1:0]            up_data_v_i;
    logic [N-1:0]            up_data_ready_o;
    logic [PW-1:0]           down_pkt_o;
    logic                    down_pkt_v_o;
    logic                    down_pkt_yumi_i;
    logic [DW-1:0]           down_data_i;
    logic                    down_data_v_i;
    logic                    down_data_ready_o;
    logic [DW-1:0]           down_data_o;
    logic                    down_data_v_o;
    logic                    down_data_yumi_i;

    always #5 clk = ~clk;

    bsg_cache_dma_sched #(
        .num_req_p             (N),
        .addr_width_p          (AW),
        .data_width_p          (DW),
        .block_size_in_words_p (BLK),
        .rd_outstanding_p      (RDO),
        .wr_outstanding_p      (WRO)
    ) dut (
        .clk_i             (clk),
        .reset_i           (reset_i),
        .up_pkt_i          (up_pkt_i),
        .up_pkt_v_i        (up_pkt_v_i),
        .up_pkt_ready_o    (up_pkt_ready_o),
        .up_data_o         (up_data_o),
        .up_data_v_o       (up_data_v_o),
        .up_data_yumi_i    (up_data_yumi_i),
        .up_data_i         (up_data_i),
        .up_data_v_i       (up_data_v_i),
        .up_data_ready_o   (up_data_ready_o),
        .down_pkt_o        (down_pkt_o),
        .down_pkt_v_o      (down_pkt_v_o),
        .down_pkt_yumi_i   (down_pkt_yumi_i),
        .down_data_i       (down_data_i),
        .down_data_v_i     (down_data_v_i),
        .down_data_ready_o (down_data_ready_o),
        .down_data_o       (down_data_o),
        .down_data_v_o     (down_data_v_o),
        .down_data_yumi_i  (down_data_yumi_i)
    );

    int unsigned n_total = 0;
    int unsigned n_pass  = 0;

    // Stimulus-side state
    bit            pend_v   [N];
    logic [PW-1:0] pend_pkt [N];
    int unsigned   evict_seq[N];
    bit            allow_new   = 1'b1;
    bit            stall_fill  = 1'b0;
    int unsigned   pkt_yumi_pct = 70;

    // Reference model: one packet may be in flight to the DMA; issued reads and
    // writes are queues of owners that complete in issue order after BLK words.
    logic [PW-1:0] exp_pkt_q[$];
    int unsigned   rd_own_q[$];
    int unsigned   wr_own_q[$];
    bit            m_busy    = 1'b0;
    int unsigned   m_busy_id = 0;
    int unsigned   m_ptr     = 0;
    int unsigned   m_rd_beat = 0;
    int unsigned   m_wr_beat = 0;
    int unsigned   m_evict_idx[N];

    function automatic logic [DW-1:0] evict_word(input int unsigned r, input int unsigned idx);
        return {16'hEE00 + 16'(r), 16'(idx), 32'(r * 32'h9E37_79B9) ^ 32'(idx)};
    endfunction

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic monitor_step();
        logic [N-1:0]  exp_rdy, exp_uv, exp_ur;
        logic [PW-1:0] p;
        bit            gfound, exp_dr, exp_dv;
        int unsigned   g, o;
        if (!reset_i) begin
            chk("rst_pkt_ready",  DW'(up_pkt_ready_o),    '0);
            chk("rst_pkt_v",      DW'(down_pkt_v_o),      '0);
            chk("rst_fill_v",     DW'(up_data_v_o),       '0);
            chk("rst_fill_ready", DW'(down_data_ready_o), '0);
            chk("rst_evict_v",    DW'(down_data_v_o),     '0);
            chk("rst_evict_rdy",  DW'(up_data_ready_o),   '0);
            exp_pkt_q.delete();
            rd_own_q.delete();
            wr_own_q.delete();
            m_busy    = 1'b0;
            m_ptr     = 0;
            m_rd_beat = 0;
            m_wr_beat = 0;
            return;
        end

        // Arbitration from the current (pre-edge) model state.
        exp_rdy = '0;
        gfound  = 1'b0;
        g       = 0;
        if (!m_busy) begin
            for (int unsigned k = 0; k < N; k++) begin
                int unsigned i;
                i = (m_ptr + k) % N;
                if (!gfound && up_pkt_v_i[i] &&
                    (up_pkt_i[i][AW] ? (wr_own_q.size() < WRO) : (rd_own_q.size() < RDO))) begin
                    gfound = 1'b1;
                    g      = i;
                end
            end
        end
        if (gfound) exp_rdy[g] = 1'b1;
        if (up_pkt_v_i != '0 || up_pkt_ready_o != '0)
            chk("grant", DW'(up_pkt_ready_o), DW'(exp_rdy));
        chk("pkt_v", DW'(down_pkt_v_o), DW'(m_busy));
        if (m_busy) chk("pkt", DW'(down_pkt_o), DW'(exp_pkt_q[0]));

        // Fill path
        exp_uv = '0;
        exp_dr = 1'b0;
        if (rd_own_q.size() != 0) begin
            o = rd_own_q[0];
            exp_uv[o] = down_data_v_i;
            exp_dr    = up_data_yumi_i[o];
        end
        chk("fill_v", DW'(up_data_v_o), DW'(exp_uv));
        chk("fill_ready", DW'(down_data_ready_o), DW'(exp_dr));
        if (down_data_v_i && exp_dr) begin
            chk("fill_data", up_data_o, down_data_i);
            m_rd_beat++;
            if (m_rd_beat == BLK) begin
                void'(rd_own_q.pop_front());
                m_rd_beat = 0;
            end
        end

        // Evict path
        exp_ur = '0;
        exp_dv = 1'b0;
        o      = 0;
        if (wr_own_q.size() != 0) begin
            o = wr_own_q[0];
            exp_dv    = up_data_v_i[o];
            exp_ur[o] = down_data_yumi_i;
        end
        chk("evict_v", DW'(down_data_v_o), DW'(exp_dv));
        chk("evict_ready", DW'(up_data_ready_o), DW'(exp_ur));
        if (exp_dv && down_data_yumi_i) begin
            chk("evict_data", down_data_o, evict_word(o, m_evict_idx[o]));
            m_evict_idx[o]++;
            m_wr_beat++;
            if (m_wr_beat == BLK) begin
                void'(wr_own_q.pop_front());
                m_wr_beat = 0;
            end
        end

        // Issue, then the new grant (after the edge).
        if (m_busy && down_pkt_yumi_i) begin
            p = exp_pkt_q.pop_front();
            if (p[AW]) wr_own_q.push_back(m_busy_id);
            else       rd_own_q.push_back(m_busy_id);
            m_busy = 1'b0;
        end
        if (gfound) begin
            exp_pkt_q.push_back(up_pkt_i[g]);
            m_busy    = 1'b1;
            m_busy_id = g;
            m_ptr     = (g + 1) % N;
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            #2;
            monitor_step();
        end
    end

    task automatic drive_cycle(input bit rst_n_val = 1'b1);
        @(negedge clk);
        reset_i = rst_n_val;
        for (int unsigned i = 0; i < N; i++) begin
            if (!pend_v[i] && allow_new && $urandom_range(0, 3) == 0) begin
                pend_v[i]   = 1'b1;
                pend_pkt[i] = {1'($urandom_range(0, 1)), 32'($urandom) & 32'hFFFF_FFC0};
            end
            up_pkt_v_i[i]  = pend_v[i];
            up_pkt_i[i]    = pend_pkt[i];
            up_data_v_i[i] = ($urandom_range(0, 3) != 0);
            up_data_i[i]   = evict_word(i, evict_seq[i]);
        end
        down_data_v_i = !stall_fill && (rd_own_q.size() != 0) && ($urandom_range(0, 3) != 0);
        down_data_i   = {$urandom, $urandom};
        #1;
        up_data_yumi_i   = up_data_v_o & N'($urandom);
        down_pkt_yumi_i  = down_pkt_v_o && ($urandom_range(0, 99) < pkt_yumi_pct);
        down_data_yumi_i = down_data_v_o && ($urandom_range(0, 2) != 0);
        #2;
        for (int unsigned i = 0; i < N; i++) begin
            if (up_pkt_ready_o[i])  pend_v[i] = 1'b0;
            if (up_data_ready_o[i]) evict_seq[i]++;
        end
    endtask

    initial begin
        bit done;
        reset_i          = 1'b0;
        up_pkt_i         = '0;
        up_pkt_v_i       = '0;
        up_data_yumi_i   = '0;
        up_data_i        = '0;
        up_data_v_i      = '0;
        down_pkt_yumi_i  = 1'b0;
        down_data_i      = '0;
        down_data_v_i    = 1'b0;
        down_data_yumi_i = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            pend_v[i]      = 1'b0;
            pend_pkt[i]    = '0;
            evict_seq[i]   = 0;
            m_evict_idx[i] = 0;
        end

        repeat (3) drive_cycle(1'b0);

        // Mixed random traffic.
        repeat (1500) drive_cycle();

        // No fills return: reads back up to the limit while writes keep flowing.
        stall_fill = 1'b1;
        repeat (300) drive_cycle();
        stall_fill = 1'b0;

        // DMA is slow to accept packets.
        pkt_yumi_pct = 15;
        repeat (300) drive_cycle();
        pkt_yumi_pct = 70;

        // Reset in the middle of a fill burst, then carry on.
        for (int unsigned c = 0; c < 3000; c++) begin
            if (m_rd_beat == 3) break;
            drive_cycle();
        end
        stall_fill = 1'b1;
        repeat (3) drive_cycle(1'b0);
        stall_fill = 1'b0;
        repeat (800) drive_cycle();

        // Drain everything outstanding within a bounded number of cycles.
        allow_new = 1'b0;
        done      = 1'b0;
        for (int unsigned c = 0; c < 4000; c++) begin
            drive_cycle();
            done = (exp_pkt_q.size() == 0) && (rd_own_q.size() == 0) &&
                   (wr_own_q.size() == 0) && !m_busy &&
                   !pend_v[0] && !pend_v[1] && !pend_v[2] && !pend_v[3];
            if (done) break;
        end
        chk("drain_done", DW'(done), DW'(1));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
